// File: rtl/arbitro_sumador.sv
// Round-robin arbiter that shares one external saturating adder among N requesters.
// Each granted request takes two cycles: the operands are loaded into AdC/AdD, then the result is written.
module arbitro_sumador #(
    parameter int W = 25,
    parameter int N = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [N-1:0]          Req,
    input  logic [N*W-1:0]        OpA,
    input  logic [N*W-1:0]        OpB,
    output logic [N-1:0]          Gnt,
    output logic [N-1:0]          Done,
    output logic signed [W-1:0]   Result,
    output logic                  Lim,
    output logic                  Busy,
    output logic signed [W-1:0]   AdC,
    output logic signed [W-1:0]   AdD,
    input  logic signed [W-1:0]   AdS
);

    // state | meaning
    // IDLE  | no operation in progress, Req sampled
    // LOAD  | operands held on AdC/AdD, Gnt high
    // WRITE | Result/Lim registered, Done high, Req sampled again
    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    state_t          state, state_nxt;
    logic [PW-1:0]   last_gnt;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   j_idx;
    logic            win_found;
    logic            take;
    int              j;
    logic [N-1:0]    gnt_nxt;
    logic [W-1:0]    opa_sel, opb_sel;
    logic            lim_nxt;

    // Search starts just after the last winner and wraps around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        j_idx     = '0;
        for (int i = 0; i < N; i++) begin
            j     = (int'(last_gnt) + 1 + i) % N;
            j_idx = PW'(j);
            if (!win_found && Req[j_idx]) begin
                win_found = 1'b1;
                win_idx   = j_idx;
            end
        end
    end

    assign gnt_nxt = {{(N-1){1'b0}}, 1'b1} << win_idx;
    assign opa_sel = OpA[int'(win_idx)*W +: W];
    assign opb_sel = OpB[int'(win_idx)*W +: W];
    assign lim_nxt = (AdC[W-1] == AdD[W-1]) && (AdS == (AdC[W-1] ? MINV : MAXV));

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE, WRITE: begin
                if (win_found) begin
                    state_nxt = LOAD;
                    take      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD:    state_nxt = WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            last_gnt <= PW'(N-1);
            Gnt      <= '0;
            Done     <= '0;
            Result   <= '0;
            Lim      <= 1'b0;
            Busy     <= 1'b0;
            AdC      <= '0;
            AdD      <= '0;
        end else begin
            state <= state_nxt;
            Busy  <= (state_nxt != IDLE);
            Gnt   <= take ? gnt_nxt : '0;
            Done  <= (state == LOAD) ? Gnt : '0;
            if (take) begin
                AdC      <= opa_sel;
                AdD      <= opb_sel;
                last_gnt <= win_idx;
            end
            if (state == LOAD) begin
                Result <= AdS;
                Lim    <= lim_nxt;
            end
        end
    end

endmodule
